// File: rtl/mcycle_pkg.sv
// Shared definitions for the multi-cycle datapath: opcodes, FSM encoding
// and instruction field positions.
`timescale 1ns/1ps
package mcycle_pkg;

  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_ADD   = 6'b000001;
  localparam logic [5:0] OP_SUB   = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b000011;
  localparam logic [5:0] OP_OR    = 6'b000100;
  localparam logic [5:0] OP_LOAD  = 6'b001101;
  localparam logic [5:0] OP_LOADI = 6'b001110;
  localparam logic [5:0] OP_STORE = 6'b001111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_e;

  // rt and imm overlap in the low half of the word
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS_MSB  = 20;
  localparam int RS_LSB  = 16;
  localparam int RT_MSB  = 15;
  localparam int RT_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/mcycle_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Register 0 and out-of-range indices always read as zero.
`timescale 1ns/1ps
module mcycle_regfile #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        raddr_a_i,
  input  logic [4:0]        raddr_b_i,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  localparam int         IDX_W     = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

  logic [DATA_W-1:0] regs_q [REG_COUNT];

  logic wr_ok;
  logic rd_a_ok;
  logic rd_b_ok;

  assign wr_ok   = we_i && (waddr_i != 5'd0) && ({1'b0, waddr_i} < REG_LIMIT);
  assign rd_a_ok = (raddr_a_i != 5'd0) && ({1'b0, raddr_a_i} < REG_LIMIT);
  assign rd_b_ok = (raddr_b_i != 5'd0) && ({1'b0, raddr_b_i} < REG_LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[waddr_i[IDX_W-1:0]] <= wdata_i;
    end
  end

  assign rdata_a_o = rd_a_ok ? regs_q[raddr_a_i[IDX_W-1:0]] : '0;
  assign rdata_b_o = rd_b_ok ? regs_q[raddr_b_i[IDX_W-1:0]] : '0;

endmodule

// File: rtl/mcycle_datapath.sv
// Multi-cycle datapath: IDLE -> DECODE -> EXECUTE -> (MEM) -> WRITEBACK,
// with register file, small ALU and an inferred data RAM.
`timescale 1ns/1ps
module mcycle_datapath
  import mcycle_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int RAM_DEPTH = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instruction,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              illegal
);

  localparam int         ADDR_W    = $clog2(RAM_DEPTH);
  localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

  state_e            state_q, state_d;
  logic [31:0]       instr_q;
  logic              illegal_q;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] ram_q [RAM_DEPTH];

  logic [5:0]        opcode;
  logic [4:0]        rd_idx, rs_idx, rt_idx;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] ram_addr;

  logic is_alu, is_load, is_store, is_loadi, legal_op, bad_reg, illegal_d;
  logic [DATA_W-1:0] rdata_a, rdata_b, exec_result;
  logic reg_we, ram_we;

  function automatic logic reg_ok(input logic [4:0] idx);
    return {1'b0, idx} < REG_LIMIT;
  endfunction

  assign opcode   = instr_q[OP_MSB:OP_LSB];
  assign rd_idx   = instr_q[RD_MSB:RD_LSB];
  assign rs_idx   = instr_q[RS_MSB:RS_LSB];
  assign rt_idx   = instr_q[RT_MSB:RT_LSB];
  assign imm      = instr_q[IMM_MSB:IMM_LSB];
  assign ram_addr = imm[ADDR_W-1:0];

  assign is_alu   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_OR);
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_loadi = (opcode == OP_LOADI);
  assign legal_op = is_alu || is_load || is_store || is_loadi || (opcode == OP_NOP);

  // Only the register fields an opcode actually uses are range-checked,
  // since rt shares bits with the immediate.
  assign bad_reg   = (is_alu && (!reg_ok(rd_idx) || !reg_ok(rs_idx) || !reg_ok(rt_idx))) ||
                     ((is_load || is_store || is_loadi) && !reg_ok(rd_idx));
  assign illegal_d = !legal_op || bad_reg;

  assign reg_we = (state_q == ST_WRITEBACK) && !illegal_q && (is_alu || is_loadi || is_load);
  assign ram_we = (state_q == ST_MEM) && !illegal_q && is_store;

  mcycle_regfile #(
    .DATA_W    (DATA_W),
    .REG_COUNT (REG_COUNT)
  ) u_regfile (
    .clock     (clock),
    .reset     (reset),
    .raddr_a_i (is_store ? rd_idx : rs_idx),
    .raddr_b_i (rt_idx),
    .we_i      (reg_we),
    .waddr_i   (rd_idx),
    .wdata_i   (out_q),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b)
  );

  always_comb begin
    exec_result = '0;
    if (!illegal_q) begin
      case (opcode)
        OP_ADD:   exec_result = rdata_a + rdata_b;
        OP_SUB:   exec_result = rdata_a - rdata_b;
        OP_AND:   exec_result = rdata_a & rdata_b;
        OP_OR:    exec_result = rdata_a | rdata_b;
        OP_LOADI: exec_result = DATA_W'(imm);
        default:  exec_result = '0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    out_valid   = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = ST_DECODE;
      end
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = ((is_load || is_store) && !illegal_q) ? ST_MEM : ST_WRITEBACK;
      ST_MEM:     state_d = ST_WRITEBACK;
      ST_WRITEBACK: begin
        out_valid = 1'b1;
        illegal   = illegal_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // out_q is loaded on the edge entering WRITEBACK and doubles as the
  // register write data committed on the edge leaving it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      illegal_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && instr_valid) instr_q <= instruction;
      if (state_q == ST_DECODE) illegal_q <= illegal_d;
      if (state_q == ST_EXECUTE && state_d == ST_WRITEBACK) out_q <= exec_result;
      if (state_q == ST_MEM) out_q <= is_load ? ram_q[ram_addr] : rdata_a;
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) ram_q[ram_addr] <= rdata_a;
  end

  assign out = out_q;

endmodule

// File: tb/tb_mcycle_datapath.sv
// Directed self-checking bench: a 32-bit/32-register instance (A) and an
// 8-bit/16-register instance (B), each driven with hand-computed vectors.
`timescale 1ns/1ps
module tb_mcycle_datapath;

  localparam logic [5:0] NOP = 6'b000000, ADD = 6'b000001, SUB = 6'b000010,
                         AND_ = 6'b000011, OR_ = 6'b000100, LOAD = 6'b001101,
                         LOADI = 6'b001110, STORE = 6'b001111;

  logic        clock = 1'b0;
  logic        reset;
  logic        validA, readyA, outValidA, illegalA;
  logic [31:0] instrA, outA;
  logic        validB, readyB, outValidB, illegalB;
  logic [31:0] instrB;
  logic [7:0]  outB;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clock = ~clock;

  mcycle_datapath #(.DATA_W(32), .REG_COUNT(32), .RAM_DEPTH(256)) dutA (
    .clock (clock), .reset (reset), .instr_valid (validA), .instr_ready (readyA),
    .instruction (instrA), .out (outA), .out_valid (outValidA), .illegal (illegalA)
  );

  mcycle_datapath #(.DATA_W(8), .REG_COUNT(16), .RAM_DEPTH(256)) dutB (
    .clock (clock), .reset (reset), .instr_valid (validB), .instr_ready (readyB),
    .instruction (instrB), .out (outB), .out_valid (outValidB), .illegal (illegalB)
  );

  function automatic logic [31:0] mkR(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rd), 5'(rs), 5'(rt), 11'b0};
  endfunction

  function automatic logic [31:0] mkI(input logic [5:0] op, input int rd, input logic [15:0] imm);
    return {op, 5'(rd), 5'b0, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one instruction and follow it to retirement. edges counts the
  // accepting edge as 1; an instruction that never retires yields 11.
  task automatic applyStimulus(input bit sel, input logic [31:0] instr, input bit holdValid,
                               output logic [31:0] res, output logic ill, output int edges,
                               output bit sawReady);
    int waitCnt = 0;
    sawReady = 1'b0;
    @(negedge clock);
    while (!(sel ? readyB : readyA) && waitCnt < 20) begin
      @(negedge clock);
      waitCnt++;
    end
    if (waitCnt == 20) checkOutput("ready_timeout", 32'd0, 32'd1);
    if (sel) begin instrB = instr; validB = 1'b1; end
    else     begin instrA = instr; validA = 1'b1; end
    @(posedge clock);
    edges = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (!holdValid) begin
        if (sel) begin validB = 1'b0; instrB = 32'hFC00_0000; end
        else     begin validA = 1'b0; instrA = 32'hFC00_0000; end
      end
      if (sel ? readyB : readyA) sawReady = 1'b1;
      if (sel ? outValidB : outValidA) break;
      @(posedge clock);
      edges++;
    end
    res = sel ? {24'b0, outB} : outA;
    ill = sel ? illegalB : illegalA;
    validA = 1'b0;
    validB = 1'b0;
    @(negedge clock);
    checkOutput("pulse_width", {31'b0, sel ? outValidB : outValidA}, 32'd0);
    checkOutput("ready_after", {31'b0, sel ? readyB : readyA}, 32'd1);
  endtask

  task automatic run(input bit sel, input string tag, input logic [31:0] instr,
                     input logic [31:0] expOut, input logic expIll, input int expEdges);
    logic [31:0] res;
    logic        ill;
    int          edges;
    bit          sawReady;
    applyStimulus(sel, instr, 1'b0, res, ill, edges, sawReady);
    checkOutput({tag, "/out"}, res, expOut);
    checkOutput({tag, "/illegal"}, {31'b0, ill}, {31'b0, expIll});
    checkOutput({tag, "/edges"}, edges, expEdges);
  endtask

  // Start an instruction on A and pulse reset after n edges (2 = EXECUTE,
  // 3 = MEM); the aborted instruction must never retire.
  task automatic abortWithReset(input string tag, input logic [31:0] instr, input int n);
    int pulses = 0;
    @(negedge clock);
    instrA = instr;
    validA = 1'b1;
    @(posedge clock);
    @(negedge clock);
    validA = 1'b0;
    repeat (n - 1) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clock);
    checkOutput({tag, "/ready"}, {31'b0, readyA}, 32'd1);
    checkOutput({tag, "/out"}, outA, 32'd0);
    repeat (4) begin
      if (outValidA) pulses++;
      @(negedge clock);
    end
    checkOutput({tag, "/no_retire"}, pulses, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] res;
    logic        ill;
    int          edges;
    bit          sawReady;

    reset = 1'b1;
    validA = 1'b0; instrA = '0;
    validB = 1'b0; instrB = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset/ready", {31'b0, readyA}, 32'd1);
    checkOutput("reset/out", outA, 32'd0);
    checkOutput("reset/out_valid", {31'b0, outValidA}, 32'd0);
    checkOutput("reset/illegal", {31'b0, illegalA}, 32'd0);
    checkOutput("reset/outB", {24'b0, outB}, 32'd0);

    run(0, "loadi_r1", mkI(LOADI, 1, 16'h00A5), 32'h0000_00A5, 1'b0, 3);
    run(0, "store_10", mkI(STORE, 1, 16'h0010), 32'h0000_00A5, 1'b0, 4);
    run(0, "load_10", mkI(LOAD, 9, 16'h0010), 32'h0000_00A5, 1'b0, 4);
    repeat (3) @(negedge clock);
    checkOutput("out_hold", outA, 32'h0000_00A5);

    run(0, "loadi_r2", mkI(LOADI, 2, 16'd5), 32'd5, 1'b0, 3);
    run(0, "loadi_r3", mkI(LOADI, 3, 16'd7), 32'd7, 1'b0, 3);
    run(0, "sub", mkR(SUB, 4, 2, 3), 32'hFFFF_FFFE, 1'b0, 3);
    run(0, "add", mkR(ADD, 10, 2, 3), 32'd12, 1'b0, 3);
    run(0, "and", mkR(AND_, 11, 2, 3), 32'd5, 1'b0, 3);
    run(0, "or", mkR(OR_, 12, 2, 3), 32'd7, 1'b0, 3);
    run(0, "add_wrap", mkR(ADD, 11, 4, 3), 32'd5, 1'b0, 3);

    run(0, "store_wrap", mkI(STORE, 1, 16'h0105), 32'h0000_00A5, 1'b0, 4);
    run(0, "load_wrap", mkI(LOAD, 6, 16'h0005), 32'h0000_00A5, 1'b0, 4);
    run(0, "nop", mkR(NOP, 0, 0, 0), 32'd0, 1'b0, 3);

    run(0, "bad_opcode", {6'b111111, 5'd1, 5'd2, 5'd3, 11'b0}, 32'd0, 1'b1, 3);
    run(0, "r1_intact", mkR(OR_, 13, 1, 0), 32'h0000_00A5, 1'b0, 3);

    applyStimulus(0, mkI(LOADI, 0, 16'h1234), 1'b1, res, ill, edges, sawReady);
    checkOutput("loadi_r0/out", res, 32'h0000_1234);
    checkOutput("loadi_r0/edges", edges, 3);
    checkOutput("busy_ready", {31'b0, sawReady}, 32'd0);
    run(0, "add_r0", mkR(ADD, 5, 0, 0), 32'd0, 1'b0, 3);

    abortWithReset("abort_exec", mkI(LOADI, 7, 16'd9), 2);
    run(0, "r7_zero", mkR(OR_, 8, 7, 0), 32'd0, 1'b0, 3);
    run(0, "r1_cleared", mkR(OR_, 14, 1, 0), 32'd0, 1'b0, 3);
    run(0, "ram_kept", mkI(LOAD, 6, 16'h0010), 32'h0000_00A5, 1'b0, 4);
    abortWithReset("abort_mem", mkI(STORE, 0, 16'h0010), 3);
    run(0, "store_aborted", mkI(LOAD, 6, 16'h0010), 32'h0000_00A5, 1'b0, 4);

    run(1, "B_loadi_r2", mkI(LOADI, 2, 16'd5), 32'h05, 1'b0, 3);
    run(1, "B_loadi_r3", mkI(LOADI, 3, 16'd7), 32'h07, 1'b0, 3);
    run(1, "B_sub", mkR(SUB, 4, 2, 3), 32'hFE, 1'b0, 3);
    run(1, "B_trunc", mkI(LOADI, 1, 16'h1234), 32'h34, 1'b0, 3);
    run(1, "B_rd20", mkI(LOADI, 20, 16'd1), 32'd0, 1'b1, 3);
    run(1, "B_rt17", mkR(ADD, 1, 2, 17), 32'd0, 1'b1, 3);
    run(1, "B_load_rd20", mkI(LOAD, 20, 16'h0010), 32'd0, 1'b1, 3);
    run(1, "B_r1_intact", mkR(OR_, 5, 1, 0), 32'h34, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mcycle_datapath.md
MCYCLE_DATAPATH -- requirements
Module: mcycle_datapath

Interface
REQ-001 Parameter DATA_W, default 32, register/RAM/ALU data width (8..32).
REQ-002 Parameter REG_COUNT, default 32, register file entries (2..32).
REQ-003 Parameter RAM_DEPTH, default 256, data RAM words (power of 2, ADDR_W = clog2(RAM_DEPTH) <= 16).
REQ-004 clock  input  1  rising-edge clock, single clock domain.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 instr_valid  input  1  instruction word present.
REQ-007 instr_ready  output  1  block can accept an instruction this cycle.
REQ-008 instruction  input  32  opcode[31:26], rd[25:21], rs[20:16], rt[15:11], imm[15:0].
REQ-009 out  output  DATA_W  result of last retired instruction.
REQ-010 out_valid  output  1  one-cycle pulse on retirement.
REQ-011 illegal  output  1  one-cycle pulse with out_valid when retired instruction was illegal.

Function
REQ-012 Opcodes SHALL be: NOP 000000, ADD 000001, SUB 000010, AND 000011, OR 000100, LOAD 001101, LOADI 001110, STORE 001111; all others illegal.
REQ-013 FSM states SHALL be IDLE, DECODE, EXECUTE, MEM, WRITEBACK; transfer occurs on a rising edge with instr_valid && instr_ready.
REQ-014 instr_ready SHALL be 1 only in IDLE; instruction is captured into an internal register on acceptance and input changes afterwards have no effect.
REQ-015 Transitions: IDLE->DECODE on acceptance; DECODE->EXECUTE; EXECUTE->MEM for LOAD/STORE, else ->WRITEBACK; MEM->WRITEBACK; WRITEBACK->IDLE.
REQ-016 out_valid SHALL be high for exactly the WRITEBACK cycle: 3 edges after the accepting edge for NOP/ALU/LOADI/illegal, 4 edges for LOAD/STORE.
REQ-017 ADD/SUB/AND/OR: reg[rd] <= reg[rs] op reg[rt], modulo 2^DATA_W, carry/borrow discarded.
REQ-018 LOADI: reg[rd] <= imm zero-extended or truncated to DATA_W.
REQ-019 LOAD: reg[rd] <= RAM[imm[ADDR_W-1:0]]; STORE: RAM[imm[ADDR_W-1:0]] <= reg[rd]; upper imm bits ignored (address wraps).
REQ-020 Register 0 SHALL read as zero; writes to register 0 are discarded but out still shows the computed value.
REQ-021 Any register index >= REG_COUNT SHALL make the instruction illegal.
REQ-022 Illegal instructions SHALL write no register or RAM, drive out = 0, and pulse illegal with out_valid.
REQ-023 out SHALL update only in WRITEBACK: written value for ALU/LOADI/LOAD, stored data for STORE, 0 for NOP; it holds between retirements.
REQ-024 Register writes and STORE RAM writes SHALL commit on the edge leaving WRITEBACK/MEM respectively; a following instruction sees the updated value.

Reset
REQ-025 Reset SHALL force state IDLE, instr_ready 1, out 0, out_valid 0, illegal 0, all registers 0.
REQ-026 RAM contents SHALL NOT be cleared by reset.
REQ-027 Reset asserted mid-instruction SHALL abort it with no register write; a STORE aborted before leaving MEM SHALL not write RAM.

Structure
REQ-028 Package mcycle_pkg SHALL hold opcode constants, FSM state encoding and instruction field bit positions.
REQ-029 Register file SHALL be sub-module mcycle_regfile (two async read ports, one sync write port, REG_COUNT/DATA_W parameters, async reset).
REQ-030 Data RAM SHALL be inferred inside mcycle_datapath with synchronous write and read registered in MEM.

Verification
REQ-031 LOADI r1,0x00A5 -> out_valid 3 edges after accept, out = 0x000000A5, then STORE r1,@0x10 -> out = 0xA5 at 4 edges.
REQ-032 LOADI r2,5; LOADI r3,7; SUB r4,r2,r3 -> out = 0xFFFFFFFE (DATA_W=32); with DATA_W=8 -> out = 0xFE.
REQ-033 STORE r1,@0x0105 with RAM_DEPTH=256 then LOAD r6,@0x0005 -> out = 0xA5 (address wrap).
REQ-034 Opcode 111111, or rd=20 with REG_COUNT=16 -> illegal and out_valid pulse together, out = 0, no state change.
REQ-035 LOADI r0,0x1234 then ADD r5,r0,r0 -> out = 0x1234 then 0; instr_valid held high while busy -> instr_ready 0, no second capture.
REQ-036 Reset pulsed in EXECUTE of LOADI r7,9 -> instr_ready 1 next cycle, r7 reads 0, no out_valid.
